// File: rtl/jt10_adpcm_pkg.sv
// Shared definitions for the ADPCM address sequencer.
// slot_act_e : what a channel slot does (idle, key-off, key-on, fetch, hold).
// ptr_width  : nibble-pointer width for a given ROM byte-address width.
package jt10_adpcm_pkg;

    typedef enum logic [2:0] {
        SLOT_IDLE,
        SLOT_KOFF,
        SLOT_KON,
        SLOT_FETCH,
        SLOT_HOLD
    } slot_act_e;

    // One extra LSB selects the nibble inside the addressed byte.
    function automatic int unsigned ptr_width(input int unsigned aw);
        return aw + 1;
    endfunction

endpackage

// File: rtl/jt10_adpcm_addr_seq_if.sv
// ROM fetch / nibble decoder strobe bundle driven once per channel slot.
// addr_out : ROM byte address      sel   : 0 high nibble, 1 low nibble
// roe_n    : ROM output enable (L) decon : decoder enable
// clr      : decoder state reset for the slot's channel
interface jt10_adpcm_addr_seq_if #(
    parameter int unsigned AW = 20
);
    logic [AW-1:0] addr_out;
    logic          sel;
    logic          roe_n;
    logic          decon;
    logic          clr;

    modport master (output addr_out, sel, roe_n, decon, clr);
    modport slave  (input  addr_out, sel, roe_n, decon, clr);
endinterface

// File: rtl/jt10_adpcm_ch_ram.sv
// Per-channel state array for the address sequencer.
// rd_*   : state of channel rd_ch (zero when rd_ch >= CH)
// up_*   : slot update written back to channel rd_ch when up_en
// wr_*   : start/end register write port, ignored for wr_ch >= CH
// on_vec : playing flags of all channels
module jt10_adpcm_ch_ram
    import jt10_adpcm_pkg::*;
#(
    parameter  int unsigned CH  = 6,
    parameter  int unsigned CW  = 3,
    parameter  int unsigned AW  = 20,
    parameter  int unsigned BLK = 8,
    localparam int unsigned SW  = AW - BLK,
    localparam int unsigned PW  = ptr_width(AW)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CW-1:0] rd_ch,
    output logic [PW-1:0] rd_ptr,
    output logic          rd_on,
    output logic          rd_skip,
    output logic          rd_lclr,
    output logic [SW-1:0] rd_start,
    output logic [SW-1:0] rd_end,
    input  logic          up_en,
    input  logic [PW-1:0] up_ptr,
    input  logic          up_on,
    input  logic          up_skip,
    input  logic          up_lclr,
    input  logic          wr_start,
    input  logic          wr_end,
    input  logic [CW-1:0] wr_ch,
    input  logic [SW-1:0] wr_data,
    output logic [CH-1:0] on_vec
);

    localparam int unsigned IW = (CH > 1) ? $clog2(CH) : 1;

    logic [PW-1:0] ptr_q   [CH];
    logic [SW-1:0] start_q [CH];
    logic [SW-1:0] end_q   [CH];
    logic [CH-1:0] on_q;
    logic [CH-1:0] skip_q;
    logic [CH-1:0] lclr_q;     // loop restart: raise clr on the following slot

    logic          rd_ok;
    logic          wr_ok;
    logic [IW-1:0] rd_idx;
    logic [IW-1:0] wr_idx;

    assign rd_ok  = 32'(rd_ch) < CH;
    assign wr_ok  = 32'(wr_ch) < CH;
    assign rd_idx = IW'(rd_ch);
    assign wr_idx = IW'(wr_ch);

    // Read port at the slot channel
    always_comb begin
        rd_ptr   = '0;
        rd_on    = 1'b0;
        rd_skip  = 1'b0;
        rd_lclr  = 1'b0;
        rd_start = '0;
        rd_end   = '0;
        if (rd_ok) begin
            rd_ptr   = ptr_q[rd_idx];
            rd_on    = on_q[rd_idx];
            rd_skip  = skip_q[rd_idx];
            rd_lclr  = lclr_q[rd_idx];
            rd_start = start_q[rd_idx];
            rd_end   = end_q[rd_idx];
        end
    end

    // Slot write-back plus the independent start/end register port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(CH); i++) begin
                ptr_q[i]   <= '0;
                start_q[i] <= '0;
                end_q[i]   <= '0;
            end
            on_q   <= '0;
            skip_q <= '0;
            lclr_q <= '0;
        end else begin
            if (up_en && rd_ok) begin
                ptr_q[rd_idx]  <= up_ptr;
                on_q[rd_idx]   <= up_on;
                skip_q[rd_idx] <= up_skip;
                lclr_q[rd_idx] <= up_lclr;
            end
            if (wr_start && wr_ok) start_q[wr_idx] <= wr_data;
            if (wr_end && wr_ok)   end_q[wr_idx]   <= wr_data;
        end
    end

    assign on_vec = on_q;

endmodule

// File: rtl/jt10_adpcm_addr_seq.sv
// ADPCM ROM address sequencer for CH time-multiplexed channels.
// clk, rst_n          : clock, async active-low reset
// cen, cur_ch         : slot enable and the channel served by the slot
// key_on/key_off      : per-channel start/stop pulses (held pending until the slot)
// loop_en             : per-channel loop mode, sampled at end of sample
// wr_start/wr_end/... : start/end register write, value in 2^BLK byte blocks
// rom                 : ROM address / nibble select / strobes, registered per slot
// flags, clr_flags    : sticky end-of-sample flags and their level clear
// busy                : channel is playing
module jt10_adpcm_addr_seq
    import jt10_adpcm_pkg::*;
#(
    parameter  int unsigned CH  = 6,
    parameter  int unsigned CW  = 3,
    parameter  int unsigned AW  = 20,
    parameter  int unsigned BLK = 8,
    localparam int unsigned SW  = AW - BLK,
    localparam int unsigned PW  = ptr_width(AW)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cen,
    input  logic [CW-1:0]         cur_ch,
    input  logic [CH-1:0]         key_on,
    input  logic [CH-1:0]         key_off,
    input  logic [CH-1:0]         loop_en,
    input  logic                  wr_start,
    input  logic                  wr_end,
    input  logic [CW-1:0]         wr_ch,
    input  logic [SW-1:0]         wr_data,
    jt10_adpcm_addr_seq_if.master rom,
    output logic [CH-1:0]         flags,
    input  logic [CH-1:0]         clr_flags,
    output logic [CH-1:0]         busy
);

    localparam int unsigned IW = (CH > 1) ? $clog2(CH) : 1;

    logic [CH-1:0] pend_on_q;
    logic [CH-1:0] pend_off_q;
    logic [CH-1:0] flags_q;
    logic [PW-1:0] addr_q;
    logic          roe_n_q;
    logic          decon_q;
    logic          clr_q;

    logic [PW-1:0] rd_ptr;
    logic          rd_on;
    logic          rd_skip;
    logic          rd_lclr;
    logic [SW-1:0] rd_start;
    logic [SW-1:0] rd_end;

    logic          up_en;
    logic [PW-1:0] up_ptr;
    logic          up_on;
    logic          up_skip;
    logic          up_lclr;

    logic          ch_ok;
    logic [IW-1:0] ch_idx;
    logic [CH-1:0] ch_bit;
    logic [CH-1:0] cons;
    logic [CH-1:0] set_c;
    logic [PW-1:0] start_ptr;
    logic          end_hit;
    slot_act_e     act;
    logic          nxt_roe_n;
    logic          nxt_decon;
    logic          nxt_clr;
    logic          ld_addr;
    logic [PW-1:0] nxt_addr;

    jt10_adpcm_ch_ram #(
        .CH  (CH),
        .CW  (CW),
        .AW  (AW),
        .BLK (BLK)
    ) u_ram (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_ch    (cur_ch),
        .rd_ptr   (rd_ptr),
        .rd_on    (rd_on),
        .rd_skip  (rd_skip),
        .rd_lclr  (rd_lclr),
        .rd_start (rd_start),
        .rd_end   (rd_end),
        .up_en    (up_en),
        .up_ptr   (up_ptr),
        .up_on    (up_on),
        .up_skip  (up_skip),
        .up_lclr  (up_lclr),
        .wr_start (wr_start),
        .wr_end   (wr_end),
        .wr_ch    (wr_ch),
        .wr_data  (wr_data),
        .on_vec   (busy)
    );

    assign ch_ok     = 32'(cur_ch) < CH;
    assign ch_idx    = IW'(cur_ch);
    assign ch_bit    = ch_ok ? (CH'(1) << ch_idx) : '0;
    assign cons      = cen ? ch_bit : '0;
    assign start_ptr = {rd_start, {(BLK+1){1'b0}}};
    // Last nibble of the end block
    assign end_hit   = (rd_ptr[PW-1:BLK+1] == rd_end) && (&rd_ptr[BLK:0]);

    // Slot action, key-off beats key-on beats playback
    always_comb begin
        act = SLOT_IDLE;
        if (cen && ch_ok) begin
            if (pend_off_q[ch_idx])     act = SLOT_KOFF;
            else if (pend_on_q[ch_idx]) act = SLOT_KON;
            else if (rd_on)             act = SLOT_FETCH;
            else                        act = SLOT_HOLD;
        end
    end

    // Channel update and next output values for the slot
    always_comb begin
        up_en     = 1'b0;
        up_ptr    = rd_ptr;
        up_on     = rd_on;
        up_skip   = rd_skip;
        up_lclr   = rd_lclr;
        nxt_roe_n = 1'b1;
        nxt_decon = 1'b0;
        nxt_clr   = 1'b0;
        ld_addr   = 1'b0;
        nxt_addr  = rd_ptr;
        set_c     = '0;
        case (act)
            SLOT_KOFF: begin
                up_en   = 1'b1;
                up_on   = 1'b0;
                up_lclr = 1'b0;
                nxt_clr = 1'b1;
            end
            SLOT_KON: begin
                up_en    = 1'b1;
                up_ptr   = start_ptr;
                up_on    = 1'b1;
                up_skip  = 1'b1;
                up_lclr  = 1'b0;
                nxt_clr  = 1'b1;
                ld_addr  = 1'b1;
                nxt_addr = start_ptr;
            end
            SLOT_FETCH: begin
                up_en     = 1'b1;
                nxt_roe_n = 1'b0;
                nxt_decon = 1'b1;
                ld_addr   = 1'b1;
                if (rd_skip) begin
                    // First slot after (re)start: pointer holds, loop restart resets decoder
                    up_skip = 1'b0;
                    up_lclr = 1'b0;
                    nxt_clr = rd_lclr;
                end else if (end_hit) begin
                    set_c = ch_bit;
                    if (loop_en[ch_idx]) begin
                        up_ptr  = start_ptr;
                        up_skip = 1'b1;
                        up_lclr = 1'b1;
                    end else begin
                        up_on = 1'b0;
                    end
                end else begin
                    up_ptr = rd_ptr + PW'(1);
                end
            end
            SLOT_IDLE, SLOT_HOLD: ;
            default: ;
        endcase
    end

    // Pending keys, flags and slot output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_on_q  <= '0;
            pend_off_q <= '0;
            flags_q    <= '0;
            addr_q     <= '0;
            roe_n_q    <= 1'b1;
            decon_q    <= 1'b0;
            clr_q      <= 1'b0;
        end else begin
            // A pulse landing on the consuming clk survives for the next slot
            pend_on_q  <= (pend_on_q & ~cons) | key_on;
            pend_off_q <= (pend_off_q & ~cons) | key_off;
            flags_q    <= (flags_q & ~clr_flags) | set_c;
            if (cen) begin
                roe_n_q <= nxt_roe_n;
                decon_q <= nxt_decon;
                clr_q   <= nxt_clr;
                if (ld_addr) addr_q <= nxt_addr;
            end
        end
    end

    assign rom.addr_out = addr_q[PW-1:1];
    assign rom.sel      = addr_q[0];
    assign rom.roe_n    = roe_n_q;
    assign rom.decon    = decon_q;
    assign rom.clr      = clr_q;
    assign flags        = flags_q;

endmodule

// File: tb/tb_jt10_adpcm_addr_seq.sv
// Self-checking bench for jt10_adpcm_addr_seq (CH=6, AW=20, BLK=8).
module tb_jt10_adpcm_addr_seq;

    localparam int unsigned CH  = 6;
    localparam int unsigned CW  = 3;
    localparam int unsigned AW  = 20;
    localparam int unsigned BLK = 8;
    localparam int unsigned SW  = AW - BLK;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cen = 1'b0;
    logic [CW-1:0] cur_ch = '0;
    logic [CH-1:0] key_on = '0;
    logic [CH-1:0] key_off = '0;
    logic [CH-1:0] loop_en = '0;
    logic          wr_start = 1'b0;
    logic          wr_end = 1'b0;
    logic [CW-1:0] wr_ch = '0;
    logic [SW-1:0] wr_data = '0;
    logic [CH-1:0] flags;
    logic [CH-1:0] clr_flags = '0;
    logic [CH-1:0] busy;

    jt10_adpcm_addr_seq_if #(.AW(AW)) rom_if ();

    jt10_adpcm_addr_seq #(
        .CH  (CH),
        .CW  (CW),
        .AW  (AW),
        .BLK (BLK)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cen       (cen),
        .cur_ch    (cur_ch),
        .key_on    (key_on),
        .key_off   (key_off),
        .loop_en   (loop_en),
        .wr_start  (wr_start),
        .wr_end    (wr_end),
        .wr_ch     (wr_ch),
        .wr_data   (wr_data),
        .rom       (rom_if.master),
        .flags     (flags),
        .clr_flags (clr_flags),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            ch;
        logic          roe_n;
        logic          decon;
        logic          clr;
        bit            chk_addr;
        logic [AW-1:0] addr;
        logic          sel;
        bit            chk_busy;
        logic [CH-1:0] busy;
    } exp_t;

    typedef struct {
        logic [CH-1:0] kon;
        logic [CH-1:0] koff;
        bit            kclk;   // 1: key pulse on the slot clk itself
        int            ch;
        exp_t          e;
    } vec_t;

    exp_t  sbq[$];
    vec_t  tbl[$];
    int    checks = 0;
    int    errors = 0;
    string phase = "init";
    int    tag_ch = -1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s ch%0d %s: got 0x%0h want 0x%0h", phase, tag_ch, nm, got, want);
        end
    endtask

    function automatic exp_t mk(input logic r, input logic d, input logic c, input bit ca,
                                input logic [AW-1:0] a, input logic s,
                                input bit cb, input logic [CH-1:0] b);
        exp_t e;
        e.ch = 0; e.roe_n = r; e.decon = d; e.clr = c;
        e.chk_addr = ca; e.addr = a; e.sel = s;
        e.chk_busy = cb; e.busy = b;
        return e;
    endfunction

    function automatic exp_t e_off(input bit cb, input logic [CH-1:0] b);
        return mk(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, cb, b);
    endfunction

    task automatic add(input logic [CH-1:0] kon, input logic [CH-1:0] koff, input bit kclk,
                       input int ch, input exp_t e);
        vec_t v;
        v.kon = kon; v.koff = koff; v.kclk = kclk; v.ch = ch; v.e = e;
        tbl.push_back(v);
    endtask

    task automatic sb_check();
        exp_t e;
        if (sbq.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s sb_empty: got 0 entries want 1", phase);
            return;
        end
        e = sbq.pop_front();
        tag_ch = e.ch;
        chk("roe_n", 32'(rom_if.roe_n), 32'(e.roe_n));
        chk("decon", 32'(rom_if.decon), 32'(e.decon));
        chk("clr",   32'(rom_if.clr),   32'(e.clr));
        if (e.chk_addr) begin
            chk("addr", 32'(rom_if.addr_out), 32'(e.addr));
            chk("sel",  32'(rom_if.sel),      32'(e.sel));
        end
        if (e.chk_busy) chk("busy", 32'(busy), 32'(e.busy));
    endtask

    // One cen slot; expectation queued at drive time, checked after the edge
    task automatic slot(input int ch, input exp_t e);
        @(negedge clk);
        cen = 1'b1;
        cur_ch = CW'(ch);
        e.ch = ch;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        cen = 1'b0;
        key_on = '0;
        key_off = '0;
        sb_check();
    endtask

    task automatic pulse(input logic [CH-1:0] on_v, input logic [CH-1:0] off_v);
        @(negedge clk);
        key_on = on_v;
        key_off = off_v;
        @(posedge clk);
        #1;
        key_on = '0;
        key_off = '0;
    endtask

    task automatic wr_reg(input int ch, input logic [SW-1:0] s, input logic [SW-1:0] e);
        @(negedge clk);
        wr_ch = CW'(ch); wr_data = s; wr_start = 1'b1;
        @(posedge clk); #1;
        wr_start = 1'b0;
        @(negedge clk);
        wr_data = e; wr_end = 1'b1;
        @(posedge clk); #1;
        wr_end = 1'b0;
    endtask

    task automatic clear_flag(input logic [CH-1:0] m);
        @(negedge clk);
        clr_flags = m;
        @(posedge clk); #1;
        clr_flags = '0;
        chk("flag_clr", 32'(flags & m), 32'(0));
    endtask

    // Play one sample start=end=st on channel ch with closed-form expected addresses
    task automatic play(input int ch, input logic [SW-1:0] st, input bit lp, input bit race);
        logic [AW-1:0] base;
        logic [CH-1:0] bc;
        bc = CH'(1) << ch;
        base = AW'(st) << BLK;
        wr_reg(ch, st, st);
        loop_en[ch] = lp;
        pulse(bc, '0);
        slot(ch, mk(1'b1, 1'b0, 1'b1, 1'b1, base, 1'b0, 1'b1, bc));
        slot(ch, mk(1'b0, 1'b1, 1'b0, 1'b1, base, 1'b0, 1'b1, bc));
        for (int i = 0; i < 512; i++) begin
            if (race && i == 511) clr_flags = bc;
            slot(ch, mk(1'b0, 1'b1, 1'b0, 1'b1, base + AW'(i / 2), i[0], 1'b1,
                        (lp || i < 511) ? bc : '0));
            clr_flags = '0;
            if (i == 510) chk("flag_pre", 32'(flags & bc), 32'(0));
        end
        chk("flag_end", 32'(flags & bc), 32'(bc));
        if (lp) begin
            slot(ch, mk(1'b0, 1'b1, 1'b1, 1'b1, base, 1'b0, 1'b1, bc));
            slot(ch, mk(1'b0, 1'b1, 1'b0, 1'b1, base, 1'b0, 1'b1, bc));
            slot(ch, mk(1'b0, 1'b1, 1'b0, 1'b1, base, 1'b1, 1'b1, bc));
            chk("flag_keep", 32'(flags & bc), 32'(bc));
            pulse('0, bc);
            slot(ch, mk(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b1, '0));
            loop_en[ch] = 1'b0;
        end else begin
            slot(ch, e_off(1'b1, '0));
        end
    endtask

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] b;

        // Table: ch1 start=0x020 end=0x021 -> base address 0x02000
        add(6'h02, 6'h02, 1'b0, 1, mk(1, 0, 1, 0, '0, 0, 1, 6'h00));          // on+off collide
        add(6'h00, 6'h00, 1'b0, 1, e_off(1'b1, 6'h00));
        add(6'h02, 6'h00, 1'b0, 1, mk(1, 0, 1, 1, 20'h02000, 0, 1, 6'h02));   // key on
        add(6'h00, 6'h00, 1'b0, 1, mk(0, 1, 0, 1, 20'h02000, 0, 1, 6'h02));   // skip slot
        add(6'h00, 6'h00, 1'b0, 1, mk(0, 1, 0, 1, 20'h02000, 0, 1, 6'h02));
        add(6'h00, 6'h00, 1'b0, 1, mk(0, 1, 0, 1, 20'h02000, 1, 1, 6'h02));
        add(6'h00, 6'h00, 1'b0, 6, e_off(1'b1, 6'h02));                        // idle slots
        add(6'h00, 6'h00, 1'b0, 7, e_off(1'b1, 6'h02));
        add(6'h00, 6'h00, 1'b0, 1, mk(0, 1, 0, 1, 20'h02001, 0, 1, 6'h02));
        add(6'h00, 6'h02, 1'b0, 1, mk(1, 0, 1, 0, '0, 0, 1, 6'h00));          // key off
        add(6'h00, 6'h00, 1'b0, 1, e_off(1'b1, 6'h00));
        add(6'h02, 6'h00, 1'b1, 1, e_off(1'b1, 6'h00));                        // on at consume clk
        add(6'h00, 6'h00, 1'b0, 1, mk(1, 0, 1, 1, 20'h02000, 0, 1, 6'h02));
        add(6'h00, 6'h02, 1'b1, 1, mk(0, 1, 0, 1, 20'h02000, 0, 1, 6'h02));   // off at consume clk
        add(6'h00, 6'h00, 1'b0, 1, mk(1, 0, 1, 0, '0, 0, 1, 6'h00));
        add(6'h00, 6'h00, 1'b0, 0, e_off(1'b1, 6'h00));

        phase = "reset";
        repeat (3) @(posedge clk);
        #1;
        chk("roe_n", 32'(rom_if.roe_n), 32'(1));
        chk("decon", 32'(rom_if.decon), 32'(0));
        chk("clr",   32'(rom_if.clr),   32'(0));
        chk("addr",  32'(rom_if.addr_out), 32'(0));
        chk("flags", 32'(flags), 32'(0));
        chk("busy",  32'(busy),  32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        phase = "table";
        wr_reg(1, 12'h020, 12'h021);
        foreach (tbl[i]) begin
            if (!tbl[i].kclk && (tbl[i].kon | tbl[i].koff) != '0) begin
                pulse(tbl[i].kon, tbl[i].koff);
            end else begin
                key_on = tbl[i].kon;
                key_off = tbl[i].koff;
            end
            slot(tbl[i].ch, tbl[i].e);
        end

        phase = "single";
        play(2, 12'h010, 1'b0, 1'b0);

        phase = "loop";
        clear_flag(6'h04);
        play(2, 12'h010, 1'b1, 1'b0);

        phase = "race";
        play(3, 12'h005, 1'b0, 1'b1);
        clear_flag(6'h08);

        phase = "interleave";
        for (int c = 0; c < 6; c++) wr_reg(c, SW'(12'h100 + 4 * c), SW'(12'h100 + 4 * c));
        pulse(6'h3F, '0);
        for (int r = 0; r < 10; r++) begin
            for (int c = 0; c < 8; c++) begin
                if (c >= 6) begin
                    slot(c, e_off(1'b0, '0));
                end else begin
                    b = AW'(32'h100 + 4 * c) << BLK;
                    if (r == 0)      slot(c, mk(1, 0, 1, 1, b, 0, 0, '0));
                    else if (r == 1) slot(c, mk(0, 1, 0, 1, b, 0, 0, '0));
                    else             slot(c, mk(0, 1, 0, 1, b + AW'((r - 2) / 2), 1'((r - 2) % 2), 0, '0));
                end
            end
            if (r == 0) chk("busy_all", 32'(busy), 32'(6'h3F));
        end

        phase = "reset_mid";
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("roe_n", 32'(rom_if.roe_n), 32'(1));
        chk("decon", 32'(rom_if.decon), 32'(0));
        chk("flags", 32'(flags), 32'(0));
        chk("busy",  32'(busy),  32'(0));
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) slot(c, e_off(1'b1, '0));
        pulse(6'h01, '0);
        slot(0, mk(1, 0, 1, 1, '0, 0, 1, 6'h01));
        slot(0, mk(0, 1, 0, 1, '0, 0, 1, 6'h01));

        phase = "end";
        tag_ch = -1;
        chk("sb_left", 32'(sbq.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
